pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch front end: it owns the architectural fetch PC and issues single-outstanding requests to instruction memory. It presents the fetched instruction with its PC to the ID stage. It consumes `PCSel` and the jump target from the branch controller, redirects fetch and kills any in-flight or buffered wrong-path instruction. It sits between the branch controller / ID stage and the instruction-memory port.

## Interface
- `RESET_PC`, default `0`: fetch PC loaded on reset, `WIDTH_PC` bits.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PCSel`  in  `WIDTH_PCSEL`  from branch controller; `PCSEL_JUMP` = redirect, `PCSEL_PC4` = sequential.
- `jump_target`  in  `WIDTH_PC`  redirect address, valid when `PCSel==PCSEL_JUMP`.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  `WIDTH_PC`  request address; memory samples it only on handshake.
- `imem_resp_valid`  in  1  one-cycle response strobe.
- `imem_resp_data`  in  32  instruction word.
- `id_ready`  in  1  ID stage consumes the instruction (low = stall).
- `if_valid`  out  1  `inst_IF`/`pc_IF` hold a valid instruction.
- `inst_IF`  out  32  fetched instruction.
- `pc_IF`  out  `WIDTH_PC`  PC of `inst_IF`; becomes `pc_ID` downstream.
- `misalign_err`  out  1  sticky, present only with `PCFETCH_MISALIGN_CHK_EN`.

## Operation
- Redirect = `PCSel==PCSEL_JUMP`. It is honoured in every state and takes priority over `id_ready`.
- FSM states and transitions:
  - **S_REQ**: `imem_req_valid=1`, `imem_addr=pc`.
    - Handshake without redirect: `pc<=pc+4`, go to S_WAIT.
    - Handshake with redirect: the accepted request is wrong-path, so set `kill<=1`, set `pc<=jump_target`, go to S_WAIT.
    - Redirect without handshake: `pc<=jump_target`, stay in S_REQ. The address may change before acceptance.
  - **S_WAIT**: `imem_req_valid=0`.
    - Redirect without response: `kill<=1`, `pc<=jump_target`.
    - `imem_resp_valid` with `kill` or with a same-cycle redirect: discard the data, clear `kill`, go to S_REQ.
    - Otherwise: capture `inst_IF<=imem_resp_data`, `pc_IF<=`the issued address, set `if_valid<=1`, go to S_HOLD.
  - **S_HOLD**: `if_valid=1` and outputs held stable.
    - Redirect: `if_valid<=0`, `pc<=jump_target`, go to S_REQ.
    - `id_ready`: `if_valid<=0`, go to S_REQ.
    - Otherwise hold.
- The issued address is kept in a separate register so that `pc_IF` is correct after `pc` advances.
- PC arithmetic is modulo 2^`WIDTH_PC`; `pc+4` wraps from all-ones-minus-3 to 0 silently.
- A response arriving in S_REQ or S_HOLD is a protocol violation; it is ignored.

## Timing
- Reset values:
  - `pc=RESET_PC`
  - state S_REQ
  - `kill=0`
  - `imem_req_valid=0` during reset, 1 in the first cycle after deassertion
  - `if_valid=0`
  - `inst_IF=32'h0000_0013` (NOP)
  - `pc_IF=0`
  - `misalign_err=0`
- `imem_req_valid`/`imem_addr` are combinational from state and `pc`.
- All other outputs are registered.
- Latency: `if_valid` rises the cycle after `imem_resp_valid`.
- Peak throughput with zero-wait memory and `id_ready=1`: one instruction per 3 cycles (REQ, WAIT, HOLD).
- A redirect takes effect on the next edge: the next accepted request uses `jump_target`.
- Reset asserted mid-transaction: immediate return to reset values. A late memory response after reset is ignored (state S_REQ).

## Configuration
- `PCFETCH_MISALIGN_CHK_EN` defined:
  - A redirect with `jump_target[1:0]!=0` is suppressed: `pc` is unchanged and no kill is raised.
  - `misalign_err` is set and stays set until reset.
- Not defined: no check, no `misalign_err` port; every redirect is taken as-is.

## Structure
- Shared package/`param.v` holds:
  - `WIDTH_PC`, `WIDTH_PCSEL`
  - `PCSEL_JUMP`, `PCSEL_PC4`
  - the NOP constant
  - the FSM state encodings `FETCH_S_REQ/S_WAIT/S_HOLD`
- Single module; no sub-module needed. The FSM, `pc`, issued-address, `kill` and output registers live in one file.

## Test plan
- Reset release, `RESET_PC=0`, ready memory returning `0x00100093` → first request addr 0, `if_valid` with `pc_IF=0`, `inst_IF=0x00100093`; next request addr 4.
- `id_ready=0` for 5 cycles in S_HOLD → outputs stable, no new request; `id_ready=1` → next request issued the following cycle.
- Redirect to `0x80` in S_WAIT (request addr 8 outstanding) → response for 8 discarded, `if_valid` stays 0, next request addr `0x80`.
- Redirect to `0x40` in the same cycle as request handshake at addr 12 → that response is killed, next request addr `0x40`.
- Redirect in S_HOLD with `id_ready=1` → `if_valid` drops, next request at the target, held instruction not consumed twice.
- With macro: redirect to `0x42` → `misalign_err=1`, sequential fetch continues; reset mid-S_WAIT → all outputs return to reset values.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-unit definitions: PC/PCSel widths, PCSel codes, NOP word and
// fetch FSM state encodings.
package pc_fetch_unit_pkg;

  localparam int WIDTH_PC    = 32;
  localparam int WIDTH_PCSEL = 2;

  localparam logic [WIDTH_PCSEL-1:0] PCSEL_PC4  = 2'd0;
  localparam logic [WIDTH_PCSEL-1:0] PCSEL_JUMP = 2'd1;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_S_REQ  = 2'd0,
    FETCH_S_WAIT = 2'd1,
    FETCH_S_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: single-outstanding imem requests, redirect/kill
// handling and a one-entry IF output register. Optional macro: PCFETCH_MISALIGN_CHK_EN.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [WIDTH_PC-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH_PCSEL-1:0] PCSel,
  input  logic [WIDTH_PC-1:0]    jump_target,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [WIDTH_PC-1:0]    imem_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_resp_data,
  input  logic                   id_ready,
  output logic                   if_valid,
  output logic [31:0]            inst_IF,
  output logic [WIDTH_PC-1:0]    pc_IF
`ifdef PCFETCH_MISALIGN_CHK_EN
  ,
  output logic                   misalign_err
`endif
);

  // state      | meaning
  // S_REQ      | request at pc presented, waiting for imem_req_ready
  // S_WAIT     | one request outstanding, waiting for imem_resp_valid
  // S_HOLD     | instruction presented to ID, waiting for id_ready

  fetch_state_e          state_q, state_d;
  logic [WIDTH_PC-1:0]   pc_q, pc_d;
  logic [WIDTH_PC-1:0]   addr_q, addr_d;
  logic                  kill_q, kill_d;
  logic                  valid_q, valid_d;
  logic [31:0]           inst_q, inst_d;
  logic [WIDTH_PC-1:0]   pc_if_q, pc_if_d;
  logic                  redirect_req;
  logic                  redirect;
  logic                  handshake;

  assign redirect_req = (PCSel == PCSEL_JUMP);

`ifdef PCFETCH_MISALIGN_CHK_EN
  logic err_q, err_d;

  // A misaligned target is dropped entirely; fetch continues on the old path.
  assign redirect = redirect_req && is_word_aligned(jump_target[1:0]);
  assign err_d    = err_q || (redirect_req && !is_word_aligned(jump_target[1:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign misalign_err = err_q;
`else
  assign redirect = redirect_req;
`endif

  // Gated with rst_n so no request is presented while reset is held.
  assign imem_req_valid = rst_n && (state_q == FETCH_S_REQ);
  assign imem_addr      = pc_q;
  assign handshake      = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_if_d = pc_if_q;
    case (state_q)
      FETCH_S_REQ: begin
        if (handshake) begin
          addr_d  = pc_q;
          state_d = FETCH_S_WAIT;
          if (redirect) begin
            kill_d = 1'b1;
            pc_d   = jump_target;
          end else begin
            pc_d = pc_q + WIDTH_PC'(4);
          end
        end else if (redirect) begin
          pc_d = jump_target;
        end
      end
      FETCH_S_WAIT: begin
        if (imem_resp_valid) begin
          state_d = FETCH_S_REQ;
          kill_d  = 1'b0;
          if (redirect) begin
            pc_d = jump_target;
          end else if (!kill_q) begin
            inst_d  = imem_resp_data;
            pc_if_d = addr_q;
            valid_d = 1'b1;
            state_d = FETCH_S_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = jump_target;
        end
      end
      FETCH_S_HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = jump_target;
          state_d = FETCH_S_REQ;
        end else if (id_ready) begin
          valid_d = 1'b0;
          state_d = FETCH_S_REQ;
        end
      end
      default: begin
        state_d = FETCH_S_REQ;
        valid_d = 1'b0;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_S_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= INST_NOP;
      pc_if_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_if_q <= pc_if_d;
    end
  end

  assign if_valid = valid_q;
  assign inst_IF  = inst_q;
  assign pc_IF    = pc_if_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against a transaction-level fetch model.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [WIDTH_PCSEL-1:0] PCSel;
  logic [WIDTH_PC-1:0]    jump_target;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [WIDTH_PC-1:0]    imem_addr;
  logic                   imem_resp_valid;
  logic [31:0]            imem_resp_data;
  logic                   id_ready;
  logic                   if_valid;
  logic [31:0]            inst_IF;
  logic [WIDTH_PC-1:0]    pc_IF;
`ifdef PCFETCH_MISALIGN_CHK_EN
  logic                   misalign_err;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC('0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PCSel           (PCSel),
    .jump_target     (jump_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .inst_IF         (inst_IF),
    .pc_IF           (pc_IF)
`ifdef PCFETCH_MISALIGN_CHK_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: next fetch address, the one outstanding transaction and
  // the instruction currently offered to ID.
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_dead;
  logic [31:0] m_out_addr;
  int          m_lat;
  bit          m_held;
  logic [31:0] m_held_pc;
  logic [31:0] m_held_inst;
  bit          m_err;
  int          n_deliv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_pc   = '0;
    m_out  = 0;
    m_dead = 0;
    m_lat  = 0;
    m_held = 0;
    m_err  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_if_valid"},  32'(if_valid),       32'd0);
    check({tag, "_inst_IF"},   inst_IF,             INST_NOP);
    check({tag, "_pc_IF"},     pc_IF,               32'd0);
`ifdef PCFETCH_MISALIGN_CHK_EN
    check({tag, "_misalign"},  32'(misalign_err),   32'd0);
`endif
  endtask

  // Called at a negedge: compare, pick inputs, advance model, step one cycle.
  task automatic run_cycle(input bit allow_redirect);
    bit          req_exp, rdy, rsp, idr, jmp, take;
    logic [31:0] tgt, rdata;

    req_exp = !m_out && !m_held;
    check("req_valid", 32'(imem_req_valid), 32'(req_exp));
    if (req_exp) check("req_addr", imem_addr, m_pc);
    check("if_valid", 32'(if_valid), 32'(m_held));
    if (m_held) begin
      check("pc_IF", pc_IF, m_held_pc);
      check("inst_IF", inst_IF, m_held_inst);
    end
`ifdef PCFETCH_MISALIGN_CHK_EN
    check("misalign_err", 32'(misalign_err), 32'(m_err));
`endif

    rdy   = ($urandom_range(0, 9) < 7);
    idr   = ($urandom_range(0, 1) == 1);
    rsp   = 0;
    rdata = $urandom;
    if (m_out && m_lat == 0) begin
      rsp   = 1;
      rdata = mem_word(m_out_addr);
    end else if (!m_out && $urandom_range(0, 19) == 0) begin
      rsp = 1;
    end
    jmp = allow_redirect && ($urandom_range(0, 7) == 0);
    case ($urandom_range(0, 3))
      0:       tgt = 32'hFFFF_FFF8;
      3:       tgt = (32'($urandom_range(0, 1023)) << 2)
`ifdef PCFETCH_MISALIGN_CHK_EN
                     | 32'($urandom_range(0, 3))
`endif
                     ;
      default: tgt = 32'($urandom_range(0, 1023)) << 2;
    endcase
    if (!jmp) tgt = $urandom;

    PCSel           = jmp ? PCSEL_JUMP : PCSEL_PC4;
    jump_target     = tgt;
    imem_req_ready  = rdy;
    imem_resp_valid = rsp;
    imem_resp_data  = rdata;
    id_ready        = idr;

    take = jmp;
`ifdef PCFETCH_MISALIGN_CHK_EN
    if (jmp && tgt[1:0] != 2'b00) begin
      take  = 0;
      m_err = 1;
    end
`endif

    if (req_exp) begin
      if (rdy) begin
        m_out      = 1;
        m_out_addr = m_pc;
        m_dead     = take;
        m_lat      = $urandom_range(0, 2);
        m_pc       = take ? tgt : m_pc + 32'd4;
      end else if (take) begin
        m_pc = tgt;
      end
    end else if (m_out) begin
      if (rsp) begin
        m_out = 0;
        if (!m_dead && !take) begin
          m_held      = 1;
          m_held_pc   = m_out_addr;
          m_held_inst = rdata;
        end
        m_dead = 0;
        if (take) m_pc = tgt;
      end else begin
        if (take) begin
          m_dead = 1;
          m_pc   = tgt;
        end
        m_lat--;
      end
    end else if (m_held) begin
      if (take) begin
        m_held = 0;
        m_pc   = tgt;
      end else if (idr) begin
        m_held = 0;
        n_deliv++;
      end
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    PCSel           = PCSEL_PC4;
    jump_target     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    id_ready        = 1'b0;
    n_deliv         = 0;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    #1;

    // Straight-line warm-up without redirects, then the randomized run.
    for (int i = 0; i < 40; i++) run_cycle(1'b0);
    for (int i = 0; i < 1500; i++) run_cycle(1'b1);

    // Asynchronous reset in the middle of traffic.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    #1;

    // Late response straight after reset must be ignored.
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_addr", imem_addr, 32'd0);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    PCSel           = PCSEL_PC4;
    @(posedge clk);
    @(negedge clk);
    check("late_rsp_if_valid", 32'(if_valid), 32'd0);
    check("late_rsp_req_valid", 32'(imem_req_valid), 32'd1);

    for (int i = 0; i < 1500; i++) run_cycle(1'b1);

    n_cmp++;
    if (n_deliv < 20) begin
      n_bad++;
      $display("FAIL deliveries: got %0d expected at least 20", n_deliv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
